// File: rtl/sb_param_shadowed_pkg.sv
// +----------------------------------------------------------------------------+
// | sb_param_pkg : sizing helpers and mux source-index map for the corner SB   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package sb_param_pkg;

  function automatic int sel_width(input int mux_in);
    return (mux_in < 2) ? 1 : $clog2(mux_in);
  endfunction

  function automatic int cfg_bits(input int chan_w, input int mux_in);
    return 2 * chan_w * sel_width(mux_in);
  endfunction

  // Input 0 of each mux is the neighbouring track of the other channel; inputs
  // 1.. stride through the pin bus in steps of chan_w.
  function automatic int src_index(input int m, input int k, input int chan_w,
                                   input int top_pins, input int right_pins);
    int i;
    if (m < chan_w) begin
      if (k == 0) return (m + 1) % chan_w;
      return (m + (k - 1) * chan_w) % top_pins;
    end
    i = m - chan_w;
    if (k == 0) return (i + chan_w - 1) % chan_w;
    return (i + (k - 1) * chan_w) % right_pins;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_param_shadowed_if.sv
// +----------------------------------------------------------------------------+
// | sb_cfg_if : configuration-chain port bundle of the switch block           |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sb_cfg_if;
  logic ccff_head;
  logic ccff_en;
  logic cfg_commit;
  logic ccff_tail;
  logic cfg_ready;
  logic cfg_err;

  modport master (
    output ccff_head, ccff_en, cfg_commit,
    input  ccff_tail, cfg_ready, cfg_err
  );

  modport slave (
    input  ccff_head, ccff_en, cfg_commit,
    output ccff_tail, cfg_ready, cfg_err
  );
endinterface

`default_nettype wire

// File: rtl/sb_param_shadowed_route_mux.sv
// +----------------------------------------------------------------------------+
// | sb_route_mux : MUX_IN:1 binary-select mux, zero output for unused codes    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module sb_route_mux #(
  parameter int MUX_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic [MUX_IN-1:0] in_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic              out_o
);

  always_comb begin
    out_o = 1'b0;
    for (int k = 0; k < MUX_IN; k++) begin
      if (sel_i == SEL_W'(k)) out_o = in_i[k];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sb_param_shadowed.sv
// +----------------------------------------------------------------------------+
// | sb_param_shadowed : corner-tile switch block with shadowed config chain    |
// | Option            : SB_CFG_SHADOW_EN adds the commit-loaded active register|
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sb_param_shadowed
  import sb_param_pkg::*;
#(
  parameter int CHAN_W     = 5,
  parameter int MUX_IN     = 3,
  parameter int TOP_PINS   = 10,
  parameter int RIGHT_PINS = 10
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic [CHAN_W-1:0]     chany_top_in,
  input  logic [CHAN_W-1:0]     chanx_right_in,
  input  logic [TOP_PINS-1:0]   top_pin_in,
  input  logic [RIGHT_PINS-1:0] right_pin_in,
  output logic [CHAN_W-1:0]     chany_top_out,
  output logic [CHAN_W-1:0]     chanx_right_out,
  sb_cfg_if.slave               cfg
);

  localparam int SEL_W    = sel_width(MUX_IN);
  localparam int NUM_MUX  = 2 * CHAN_W;
  localparam int CFG_BITS = cfg_bits(CHAN_W, MUX_IN);
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  logic [CFG_BITS-1:0] chain_q, chain_d;
  logic [CFG_BITS-1:0] sel_bus;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                ready;

  assign ready = (cnt_q == CNT_FULL);

  // A commit restarts the count; a shift in the same cycle is its first bit.
  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (cfg.ccff_en) begin
      chain_d = {chain_q[CFG_BITS-2:0], cfg.ccff_head};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end
    if (cfg.cfg_commit) begin
      cnt_d = cfg.ccff_en ? CNT_W'(1) : '0;
      if (!ready) err_d = 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef SB_CFG_SHADOW_EN
  logic [CFG_BITS-1:0] active_q, active_d;

  assign active_d = cfg.cfg_commit ? chain_q : active_q;

  always_ff @(posedge prog_clk) begin
    if (pReset) active_q <= '0;
    else        active_q <= active_d;
  end

  assign sel_bus = active_q;
`else
  assign sel_bus = chain_q;
`endif

  assign cfg.ccff_tail = chain_q[CFG_BITS-1];
  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = err_q;

  for (genvar m = 0; m < NUM_MUX; m++) begin : g_mux
    logic [MUX_IN-1:0] mux_in;
    logic              mux_out;

    for (genvar k = 0; k < MUX_IN; k++) begin : g_in
      localparam int SRC = src_index(m, k, CHAN_W, TOP_PINS, RIGHT_PINS);
      if (m < CHAN_W) begin : g_top
        if (k == 0) begin : g_track
          assign mux_in[k] = chanx_right_in[SRC];
        end else begin : g_pin
          assign mux_in[k] = top_pin_in[SRC];
        end
      end else begin : g_right
        if (k == 0) begin : g_track
          assign mux_in[k] = chany_top_in[SRC];
        end else begin : g_pin
          assign mux_in[k] = right_pin_in[SRC];
        end
      end
    end

    sb_route_mux #(
      .MUX_IN (MUX_IN),
      .SEL_W  (SEL_W)
    ) u_mux (
      .in_i  (mux_in),
      .sel_i (sel_bus[m*SEL_W +: SEL_W]),
      .out_o (mux_out)
    );

    if (m < CHAN_W) begin : g_to_top
      assign chany_top_out[m] = mux_out;
    end else begin : g_to_right
      assign chanx_right_out[m-CHAN_W] = mux_out;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sb_param_shadowed.sv
// +----------------------------------------------------------------------------+
// | tb_sb_param_shadowed : directed vector bench for sb_param_shadowed         |
// | Option               : expectations follow SB_CFG_SHADOW_EN when defined   |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sb_param_shadowed;

  logic       clk;
  logic       rst;
  logic [4:0] chany_in, chanx_in, top_out, right_out;
  logic [9:0] tpin, rpin;
  int         n_cmp;
  int         n_bad;
  logic       hist[30];

  sb_cfg_if cfg_bus ();

  sb_param_shadowed dut (
    .prog_clk        (clk),
    .pReset          (rst),
    .chany_top_in    (chany_in),
    .chanx_right_in  (chanx_in),
    .top_pin_in      (tpin),
    .right_pin_in    (rpin),
    .chany_top_out   (top_out),
    .chanx_right_out (right_out),
    .cfg             (cfg_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] frame;
    logic [4:0]  chany;
    logic [4:0]  chanx;
    logic [9:0]  tp;
    logic [9:0]  rp;
    logic [4:0]  exp_top;
    logic [4:0]  exp_right;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Bit 19 goes in first so that it lands at the chain MSB.
  task automatic load_frame(input logic [19:0] f);
    for (int i = 19; i >= 0; i--) begin
      cfg_bus.ccff_head = f[i];
      cfg_bus.ccff_en   = 1'b1;
      tick();
    end
    cfg_bus.ccff_en   = 1'b0;
    cfg_bus.ccff_head = 1'b0;
  endtask

  task automatic commit();
    cfg_bus.cfg_commit = 1'b1;
    tick();
    cfg_bus.cfg_commit = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //          frame     chany     chanx     top pins        right pins      top_out   right_out
    vecs[0] = '{20'h00000, 5'b00000, 5'b00010, 10'b0000000000, 10'b0000000000, 5'b00001, 5'b00000};
    vecs[1] = '{20'h00000, 5'b00001, 5'b00001, 10'b1111111111, 10'b1111111111, 5'b10000, 5'b00010};
    vecs[2] = '{20'h55555, 5'b11111, 5'b11111, 10'b0100110110, 10'b1011001001, 5'b10110, 5'b01001};
    vecs[3] = '{20'hAAAAA, 5'b11111, 5'b11111, 10'b0110110010, 10'b1001101100, 5'b01101, 5'b10011};
    vecs[4] = '{20'hFFFFF, 5'b11111, 5'b11111, 10'b1111111111, 10'b1111111111, 5'b00000, 5'b00000};
    vecs[5] = '{20'h00C01, 5'b11111, 5'b11111, 10'b0000000000, 10'b1111111111, 5'b11110, 5'b11110};
    vecs[6] = '{20'h4E4E4, 5'b00100, 5'b10101, 10'b0010000010, 10'b0001010001, 5'b10110, 5'b11011};

    chany_in = '0; chanx_in = '0; tpin = '0; rpin = '0;
    cfg_bus.ccff_head = 1'b0; cfg_bus.ccff_en = 1'b0; cfg_bus.cfg_commit = 1'b0;
    rst = 1'b0;
    tick();

    // Reset state and default cross-channel routing
    do_reset();
    chanx_in = 5'b00010;
    #1;
    chk("reset_top_out", 32'(top_out), 32'h01);
    chk("reset_right_out", 32'(right_out), 32'h00);
    chk("reset_ready", 32'(cfg_bus.cfg_ready), 32'h0);
    chk("reset_tail", 32'(cfg_bus.ccff_tail), 32'h0);
    chk("reset_err", 32'(cfg_bus.cfg_err), 32'h0);

    // Routing table: load each frame, commit, apply inputs
    for (int v = 0; v < 7; v++) begin
      load_frame(vecs[v].frame);
      chk($sformatf("vec%0d_ready_pre", v), 32'(cfg_bus.cfg_ready), 32'h1);
      commit();
      chany_in = vecs[v].chany; chanx_in = vecs[v].chanx;
      tpin = vecs[v].tp; rpin = vecs[v].rp;
      #1;
      chk($sformatf("vec%0d_top_out", v), 32'(top_out), 32'(vecs[v].exp_top));
      chk($sformatf("vec%0d_right_out", v), 32'(right_out), 32'(vecs[v].exp_right));
    end
    chk("table_err", 32'(cfg_bus.cfg_err), 32'h0);

    // Full frame: ready timing and pin following after commit
    do_reset();
    chanx_in = 5'b11111; chany_in = '0; tpin = '0; rpin = '0;
    for (int i = 19; i >= 0; i--) begin
      cfg_bus.ccff_head = (i == 0);
      cfg_bus.ccff_en   = 1'b1;
      tick();
      if (i == 1) chk("frame_ready_19", 32'(cfg_bus.cfg_ready), 32'h0);
    end
    cfg_bus.ccff_en = 1'b0; cfg_bus.ccff_head = 1'b0;
    chk("frame_ready_20", 32'(cfg_bus.cfg_ready), 32'h1);
    commit();
    chk("frame_ready_post", 32'(cfg_bus.cfg_ready), 32'h0);
    tpin = 10'h001;
    #1;
    chk("frame_pin_hi", 32'(top_out), 32'h1F);
    tpin = 10'h3FE;
    #1;
    chk("frame_pin_lo", 32'(top_out), 32'h1E);

    // Early commit sets a sticky error
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cfg_bus.ccff_head = i[0];
      cfg_bus.ccff_en   = 1'b1;
      tick();
    end
    cfg_bus.ccff_en = 1'b0;
    chk("early_ready", 32'(cfg_bus.cfg_ready), 32'h0);
    commit();
    chk("early_err", 32'(cfg_bus.cfg_err), 32'h1);
    load_frame(20'h12345);
    commit();
    chk("early_err_sticky", 32'(cfg_bus.cfg_err), 32'h1);
    do_reset();
    chk("early_err_cleared", 32'(cfg_bus.cfg_err), 32'h0);

    // Shifting without commit
    chany_in = 5'b11111; chanx_in = 5'b11111; tpin = 10'h3FF; rpin = 10'h3FF;
    load_frame(20'h00000);
    commit();
    chk("glitch_base_top", 32'(top_out), 32'h1F);
    for (int i = 0; i < 15; i++) begin
      cfg_bus.ccff_head = 1'b1;
      cfg_bus.ccff_en   = 1'b1;
      tick();
`ifdef SB_CFG_SHADOW_EN
      chk($sformatf("glitch_top_%0d", i), 32'(top_out), 32'h1F);
      chk($sformatf("glitch_right_%0d", i), 32'(right_out), 32'h1F);
`endif
    end
    cfg_bus.ccff_en = 1'b0; cfg_bus.ccff_head = 1'b0;
`ifdef SB_CFG_SHADOW_EN
    chk("glitch_final_top", 32'(top_out), 32'h1F);
    chk("glitch_final_right", 32'(right_out), 32'h1F);
`else
    chk("glitch_final_top", 32'(top_out), 32'h00);
    chk("glitch_final_right", 32'(right_out), 32'h1C);
`endif

    // Out-of-range select forces zero
    load_frame(20'h00C00);
    commit();
    for (int i = 0; i < 4; i++) begin
      chany_in = 5'($urandom); chanx_in = 5'($urandom);
      tpin = 10'($urandom); rpin = 10'($urandom) | 10'h021;
      #1;
      chk($sformatf("oor_right0_%0d", i), 32'(right_out[0]), 32'h0);
    end

    // Shift and commit in the same cycle, then tail latency
    do_reset();
    load_frame(20'h4E4E4);
    chany_in = vecs[6].chany; chanx_in = vecs[6].chanx; tpin = vecs[6].tp; rpin = vecs[6].rp;
    cfg_bus.ccff_head = 1'b1; cfg_bus.ccff_en = 1'b1; cfg_bus.cfg_commit = 1'b1;
    hist[0] = 1'b1;
    tick();
    cfg_bus.cfg_commit = 1'b0; cfg_bus.ccff_en = 1'b0;
`ifdef SB_CFG_SHADOW_EN
    chk("both_top_out", 32'(top_out), 32'h16);
    chk("both_right_out", 32'(right_out), 32'h1B);
`else
    chk("both_top_out", 32'(top_out), 32'h00);
    chk("both_right_out", 32'(right_out), 32'h00);
`endif
    chk("both_err", 32'(cfg_bus.cfg_err), 32'h0);
    chk("both_ready", 32'(cfg_bus.cfg_ready), 32'h0);
    for (int j = 1; j < 30; j++) begin
      hist[j] = 1'($urandom_range(0, 1));
      cfg_bus.ccff_head = hist[j];
      cfg_bus.ccff_en   = 1'b1;
      tick();
      if (j == 18) chk("both_cnt_ready_lo", 32'(cfg_bus.cfg_ready), 32'h0);
      if (j == 19) chk("both_cnt_ready_hi", 32'(cfg_bus.cfg_ready), 32'h1);
      if (j >= 19) chk($sformatf("tail_%0d", j), 32'(cfg_bus.ccff_tail), 32'(hist[j-19]));
    end
    cfg_bus.ccff_en = 1'b0;
    chk("both_err_final", 32'(cfg_bus.cfg_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
